text_streamer: RTL and testbench
================================

Name: text_streamer

Overview:
- Upstream feeder for the assembler. Reads the ASCII program text from a byte-wide text BRAM and replays it twice: once for the PC-mapping pass, once for the instruction-mapping pass.
- Produces the assembler's character stream (new_line, new_character, incoming_character, line_count, char_count) and the pass indicator.
- Paces events so that each per-character interpreter sees at most one event every GAP cycles.

Parameters:
- CHAR_PER_LINE, 64, max characters per line; sets char_count width $clog2(CHAR_PER_LINE).
- NUMBER_LINES, 256, max lines; sets line_count width $clog2(NUMBER_LINES).
- TEXT_DEPTH, 16384, text BRAM depth in bytes; sets address width AW=$clog2(TEXT_DEPTH).
- BRAM_LATENCY, 2, read latency of the text BRAM in cycles (>=1).
- GAP, 2, minimum idle cycles after every emitted event (>=1).

Ports:
- clk_in  input  1  system clock.
- rst_n_in  input  1  asynchronous, active-low reset.
- start_in  input  1  one-cycle pulse; starts both passes; ignored unless IDLE or DONE.
- text_len_in  input  AW+1  number of valid bytes; sampled on start_in.
- text_addr_out  output  AW  BRAM read address.
- text_data_in  input  8  BRAM read data, valid BRAM_LATENCY cycles after the address.
- new_line  output  1  one-cycle pulse: a line begins.
- new_character  output  1  one-cycle pulse: incoming_character is valid.
- incoming_character  output  8  current character.
- line_count  output  $clog2(NUMBER_LINES)  zero-based index of the current line.
- char_count  output  $clog2(CHAR_PER_LINE)  index of the current character within its line.
- pass_out  output  2  0 idle, 1 PC_MAPPING, 2 INSTRUCTION_MAPPING; top level maps this to assembler_state.
- busy  output  1  high from start until DONE.
- done  output  1  one-cycle pulse when the second pass completes.
- error_flag  output  1  sticky line/char overflow; cleared by the next start_in.

Behaviour:
- Reset (asynchronous, rst_n_in=0): state IDLE. All pulses 0, incoming_character=0, counts=0, text_addr_out=0, pass_out=0, busy=0, error_flag=0.
- FSM states: IDLE, SOL, FETCH, WAIT, EMIT, EOL_CHAR, GAPW, PASS_END, DONE.
- IDLE/DONE + start_in: latch text_len, pass_out<=1, busy<=1, addr<=0, error_flag<=0, go to SOL.
- SOL: pulse new_line for 1 cycle; line_count is valid the same cycle; char_count<=0. Go to GAPW, then FETCH.
- FETCH: drive text_addr_out=addr. Go to WAIT and hold there BRAM_LATENCY cycles, then EMIT.
- EMIT, byte 0x0D: dropped; no pulse; addr+1; straight to FETCH.
- EMIT, byte 0x0A: go to EOL_CHAR.
- EMIT, any other byte: incoming_character<=byte, new_character pulse, char_count+1 after the pulse, addr+1, then GAPW.
- EOL_CHAR: emit new_character with 0x0A (field terminator for the interpreters), then GAPW, then SOL with line_count+1.
- GAPW: holds GAP cycles. Exits to FETCH, SOL or PASS_END as pending.
- End of text (addr==text_len, checked before FETCH): if the last emitted char was not 0x0A and the line is non-empty, emit a synthetic 0x0A new_character first. Then PASS_END.
- PASS_END: hold GAP cycles. If pass_out==1: pass_out<=2, addr<=0, line_count<=0, go to SOL. Else: done pulse, busy<=0, pass_out<=0, go to DONE.
- text_len==0: each pass is a single SOL new_line with no characters; done follows.
- Overflow: a character that would make char_count reach CHAR_PER_LINE, or a line beyond NUMBER_LINES-1, sets error_flag, abandons the run, and goes through PASS_END-free to DONE with a done pulse.
- Simultaneous events: new_line and new_character are never high in the same cycle. start_in while busy is ignored.
- Reset mid-operation: immediate return to the reset values above; no partial done.

Optional Feature:
- COMMENT_STRIP_EN defined: a '#' byte and all following bytes up to the 0x0A are suppressed (no new_character, char_count frozen). The 0x0A is still emitted.
- COMMENT_STRIP_EN undefined: '#' is passed through like any other character.

Test Plan:
- Text "add x1,x2,x3\n" (13 B), GAP=2: pass 1 shows new_line, 12 chars, a 0x0A char, then new_line. Pass 2 identical with pass_out=2. Exactly one done pulse. Consecutive pulses >=3 cycles apart.
- Text "a\r\nb" (4 B): 0x0D never appears. Output sequence new_line,'a',0x0A,new_line,'b',synthetic 0x0A. line_count 0 then 1.
- text_len=0: per pass, a single new_line and no new_character; done after the second pass.
- 64 non-newline chars with CHAR_PER_LINE=64: error_flag=1, done pulse, busy=0. A following start_in clears error_flag.
- Reset asserted during pass 2 mid-line: all outputs at reset values in the same cycle. A new start_in replays from pass 1, line 0.
- COMMENT_STRIP_EN defined, "li#xy\n": new_character only for 'l','i' and 0x0A.

Source files
------------

// File: rtl/text_streamer.sv
// text_streamer: replays program text from a byte-wide BRAM as a paced character stream, twice.
// Optional build macro COMMENT_STRIP_EN suppresses '#' comments up to end of line.
`default_nettype none

module text_streamer #(
  parameter int CHAR_PER_LINE = 64,
  parameter int NUMBER_LINES  = 256,
  parameter int TEXT_DEPTH    = 16384,
  parameter int BRAM_LATENCY  = 2,
  parameter int GAP           = 2,
  localparam int AW = $clog2(TEXT_DEPTH),
  localparam int CW = $clog2(CHAR_PER_LINE),
  localparam int LW = $clog2(NUMBER_LINES)
) (
  input  logic          clk_in,
  input  logic          rst_n_in,
  input  logic          start_in,
  input  logic [AW:0]   text_len_in,
  output logic [AW-1:0] text_addr_out,
  input  logic [7:0]    text_data_in,
  output logic          new_line,
  output logic          new_character,
  output logic [7:0]    incoming_character,
  output logic [LW-1:0] line_count,
  output logic [CW-1:0] char_count,
  output logic [1:0]    pass_out,
  output logic          busy,
  output logic          done,
  output logic          error_flag
);

  localparam int GW = (GAP > 1) ? $clog2(GAP + 1) : 1;
  localparam int BW = (BRAM_LATENCY > 1) ? $clog2(BRAM_LATENCY + 1) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_SOL, S_FETCH, S_WAIT, S_EMIT, S_EOL_CHAR, S_GAPW, S_PASS_END, S_DONE
  } state_t;

  state_t        state_q, state_d, pend_q, pend_d;
  logic [AW:0]   addr_q, addr_d, len_q, len_d;
  logic [1:0]    pass_q, pass_d;
  logic          busy_q, busy_d, err_q, err_d, done_q, done_d;
  logic          nl_q, nl_d, nc_q, nc_d;
  logic [7:0]    chr_q, chr_d;
  logic [LW-1:0] line_q, line_d;
  logic [CW-1:0] ccnt_q, ccnt_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [BW-1:0] wcnt_q, wcnt_d;
  logic          inc_q, inc_d, eot_q, eot_d;
`ifdef COMMENT_STRIP_EN
  logic          incom_q, incom_d;
`endif
  logic          w_abort;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    addr_d  = addr_q;
    len_d   = len_q;
    pass_d  = pass_q;
    busy_d  = busy_q;
    err_d   = err_q;
    done_d  = 1'b0;
    nl_d    = 1'b0;
    nc_d    = 1'b0;
    chr_d   = chr_q;
    line_d  = line_q;
    ccnt_d  = ccnt_q;
    gap_d   = gap_q;
    wcnt_d  = wcnt_q;
    inc_d   = inc_q;
    eot_d   = eot_q;
`ifdef COMMENT_STRIP_EN
    incom_d = incom_q;
`endif
    w_abort = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_in) begin
          len_d   = text_len_in;
          pass_d  = 2'd1;
          busy_d  = 1'b1;
          addr_d  = '0;
          err_d   = 1'b0;
          line_d  = '0;
          ccnt_d  = '0;
          inc_d   = 1'b0;
          eot_d   = 1'b0;
`ifdef COMMENT_STRIP_EN
          incom_d = 1'b0;
`endif
          state_d = S_SOL;
        end
      end
      S_SOL: begin
        nl_d    = 1'b1;
        ccnt_d  = '0;
        gap_d   = GW'(GAP - 1);
        pend_d  = S_FETCH;
        state_d = S_GAPW;
      end
      S_GAPW: begin
        // char_count steps the cycle after the character pulse is visible
        if (inc_q) begin
          ccnt_d = ccnt_q + 1'b1;
          inc_d  = 1'b0;
        end
        if (gap_q == '0) begin
          case (pend_q)
            S_SOL: begin
              if (line_q == LW'(NUMBER_LINES - 1)) begin
                w_abort = 1'b1;
              end else begin
                line_d  = line_q + 1'b1;
                state_d = S_SOL;
              end
            end
            S_PASS_END: begin
              gap_d   = GW'(GAP - 1);
              state_d = S_PASS_END;
            end
            default: state_d = S_FETCH;
          endcase
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      S_FETCH: begin
        if (addr_q == len_q) begin
          if (ccnt_q != '0) begin
            eot_d   = 1'b1;
            state_d = S_EOL_CHAR;
          end else begin
            gap_d   = GW'(GAP - 1);
            state_d = S_PASS_END;
          end
        end else begin
          wcnt_d  = BW'(BRAM_LATENCY - 1);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wcnt_q == '0) state_d = S_EMIT;
        else              wcnt_d  = wcnt_q - 1'b1;
      end
      S_EMIT: begin
        if (text_data_in == 8'h0D) begin
          addr_d  = addr_q + 1'b1;
          state_d = S_FETCH;
        end else if (text_data_in == 8'h0A) begin
          addr_d  = addr_q + 1'b1;
`ifdef COMMENT_STRIP_EN
          incom_d = 1'b0;
`endif
          state_d = S_EOL_CHAR;
        end
`ifdef COMMENT_STRIP_EN
        else if (incom_q || text_data_in == 8'h23) begin
          incom_d = 1'b1;
          addr_d  = addr_q + 1'b1;
          state_d = S_FETCH;
        end
`endif
        else if (ccnt_q == CW'(CHAR_PER_LINE - 1)) begin
          w_abort = 1'b1;
        end else begin
          chr_d   = text_data_in;
          nc_d    = 1'b1;
          inc_d   = 1'b1;
          addr_d  = addr_q + 1'b1;
          gap_d   = GW'(GAP - 1);
          pend_d  = S_FETCH;
          state_d = S_GAPW;
        end
      end
      S_EOL_CHAR: begin
        chr_d   = 8'h0A;
        nc_d    = 1'b1;
        gap_d   = GW'(GAP - 1);
        pend_d  = eot_q ? S_PASS_END : S_SOL;
        state_d = S_GAPW;
      end
      S_PASS_END: begin
        if (gap_q != '0) begin
          gap_d = gap_q - 1'b1;
        end else if (pass_q == 2'd1) begin
          pass_d  = 2'd2;
          addr_d  = '0;
          line_d  = '0;
          ccnt_d  = '0;
          eot_d   = 1'b0;
`ifdef COMMENT_STRIP_EN
          incom_d = 1'b0;
`endif
          state_d = S_SOL;
        end else begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          pass_d  = 2'd0;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Overflow abandons the run without a second pass
    if (w_abort) begin
      err_d   = 1'b1;
      done_d  = 1'b1;
      busy_d  = 1'b0;
      pass_d  = 2'd0;
      nc_d    = 1'b0;
      state_d = S_DONE;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= S_IDLE;
      pend_q  <= S_FETCH;
      addr_q  <= '0;
      len_q   <= '0;
      pass_q  <= 2'd0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      nl_q    <= 1'b0;
      nc_q    <= 1'b0;
      chr_q   <= 8'h00;
      line_q  <= '0;
      ccnt_q  <= '0;
      gap_q   <= '0;
      wcnt_q  <= '0;
      inc_q   <= 1'b0;
      eot_q   <= 1'b0;
`ifdef COMMENT_STRIP_EN
      incom_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      done_q  <= done_d;
      nl_q    <= nl_d;
      nc_q    <= nc_d;
      chr_q   <= chr_d;
      line_q  <= line_d;
      ccnt_q  <= ccnt_d;
      gap_q   <= gap_d;
      wcnt_q  <= wcnt_d;
      inc_q   <= inc_d;
      eot_q   <= eot_d;
`ifdef COMMENT_STRIP_EN
      incom_q <= incom_d;
`endif
    end
  end

  assign text_addr_out      = addr_q[AW-1:0];
  assign new_line           = nl_q;
  assign new_character      = nc_q;
  assign incoming_character = chr_q;
  assign line_count         = line_q;
  assign char_count         = ccnt_q;
  assign pass_out           = pass_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign error_flag         = err_q;

endmodule

`default_nettype wire

// File: tb/tb_text_streamer.sv
// tb_text_streamer: directed runs with a BRAM model and an event scoreboard for text_streamer.
`default_nettype none

module tb_text_streamer;

  localparam int CPL   = 64;
  localparam int NLINE = 256;
  localparam int DEPTH = 16384;
  localparam int LAT   = 2;
  localparam int GAP   = 2;
  localparam int AW    = 14;

  logic          clk_in = 1'b0;
  logic          rst_n_in;
  logic          start_in;
  logic [AW:0]   text_len_in;
  logic [AW-1:0] text_addr_out;
  logic [7:0]    text_data_in;
  logic          new_line, new_character;
  logic [7:0]    incoming_character;
  logic [7:0]    line_count;
  logic [5:0]    char_count;
  logic [1:0]    pass_out;
  logic          busy, done, error_flag;

  always #5 clk_in = ~clk_in;

  text_streamer #(
    .CHAR_PER_LINE(CPL), .NUMBER_LINES(NLINE), .TEXT_DEPTH(DEPTH),
    .BRAM_LATENCY(LAT), .GAP(GAP)
  ) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .start_in(start_in),
    .text_len_in(text_len_in), .text_addr_out(text_addr_out),
    .text_data_in(text_data_in), .new_line(new_line),
    .new_character(new_character), .incoming_character(incoming_character),
    .line_count(line_count), .char_count(char_count), .pass_out(pass_out),
    .busy(busy), .done(done), .error_flag(error_flag)
  );

  // Text BRAM: fixed read latency of LAT cycles
  logic [7:0] mem  [0:DEPTH-1];
  logic [7:0] pipe [0:LAT-1];
  always @(posedge clk_in) begin
    pipe[0] <= mem[text_addr_out];
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign text_data_in = pipe[LAT-1];

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          last_pulse = -1000;
  int          done_cnt = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ev(input int t, input int p, input int l,
                                     input logic [7:0] c, input int cc);
    return {6'd0, 2'(t), 2'(p), 8'(l), c, 6'(cc)};
  endfunction

  // One cycle: sample at the falling edge and score any stream event
  task automatic tick();
    logic [31:0] o, e;
    @(negedge clk_in);
    cyc++;
    if (rst_n_in) begin
      if (new_line || new_character) begin
        chk("pulse_exclusive", {63'd0, new_line & new_character}, 64'd0);
        chk("pulse_spacing", {63'd0, (cyc - last_pulse) >= GAP + 1}, 64'd1);
        last_pulse = cyc;
        o = ev(new_line ? 1 : 2, int'(pass_out), int'(line_count),
               new_line ? 8'h00 : incoming_character, int'(char_count));
        e = (exp_q.size() == 0) ? 32'hFFFF_FFFF : exp_q.pop_front();
        chk("event", {32'd0, o}, {32'd0, e});
      end
      if (done) done_cnt++;
    end
  endtask

  task automatic load(input string s);
    for (int i = 0; i < s.len(); i++) mem[i] = s[i];
  endtask

  // Reference stream for both passes, derived from the text in the BRAM model
  task automatic build_expected(input int len, output bit err);
    int line, cc;
    bit incom;
    logic [7:0] b;
    err = 1'b0;
    for (int p = 1; p <= 2; p++) begin
      line = 0; cc = 0; incom = 1'b0;
      exp_q.push_back(ev(1, p, line, 8'h00, 0));
      for (int i = 0; i < len; i++) begin
        b = mem[i];
        if (b == 8'h0D) continue;
        if (b == 8'h0A) begin
          exp_q.push_back(ev(2, p, line, 8'h0A, cc));
          line++; cc = 0; incom = 1'b0;
          exp_q.push_back(ev(1, p, line, 8'h00, 0));
          continue;
        end
`ifdef COMMENT_STRIP_EN
        if (incom || b == 8'h23) begin
          incom = 1'b1;
          continue;
        end
`endif
        if (cc == CPL - 1) begin
          err = 1'b1;
          return;
        end
        exp_q.push_back(ev(2, p, line, b, cc));
        cc++;
      end
      if (cc != 0) exp_q.push_back(ev(2, p, line, 8'h0A, cc));
    end
  endtask

  task automatic begin_run(input int len, output bit err);
    build_expected(len, err);
    done_cnt    = 0;
    text_len_in = 15'(len);
    start_in    = 1'b1;
    tick();
    start_in    = 1'b0;
    chk("start_busy", {63'd0, busy}, 64'd1);
    chk("start_pass", {62'd0, pass_out}, 64'd1);
    chk("start_err_clear", {63'd0, error_flag}, 64'd0);
  endtask

  task automatic run_text(input int len, input bit mid_start);
    bit err;
    begin_run(len, err);
    if (mid_start) begin
      repeat (20) tick();
      start_in = 1'b1;
      tick();
      start_in = 1'b0;
    end
    for (int k = 0; k < 5000 && done_cnt == 0; k++) tick();
    chk("done_seen", {63'd0, done_cnt != 0}, 64'd1);
    repeat (GAP + 4) tick();
    chk("done_once", 64'(done_cnt), 64'd1);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    chk("end_busy", {63'd0, busy}, 64'd0);
    chk("end_err", {63'd0, error_flag}, {63'd0, err});
    chk("end_pass", {62'd0, pass_out}, 64'd0);
  endtask

  initial begin
    bit err;
    bit found;
    rst_n_in    = 1'b0;
    start_in    = 1'b0;
    text_len_in = '0;
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    repeat (3) tick();
    chk("rst_pulses", {61'd0, new_line, new_character, done}, 64'd0);
    chk("rst_char", {56'd0, incoming_character}, 64'd0);
    chk("rst_counts", {50'd0, line_count, char_count}, 64'd0);
    chk("rst_addr", {50'd0, text_addr_out}, 64'd0);
    chk("rst_status", {60'd0, pass_out, busy, error_flag}, 64'd0);
    rst_n_in = 1'b1;
    tick();

    load("add x1,x2,x3"); mem[12] = 8'h0A;
    run_text(13, 1'b1);

    load("aXYb"); mem[1] = 8'h0D; mem[2] = 8'h0A;
    run_text(4, 1'b0);

    run_text(0, 1'b0);

    for (int i = 0; i < 64; i++) mem[i] = "x";
    run_text(64, 1'b0);

    load("add x1,x2,x3"); mem[12] = 8'h0A;
    run_text(13, 1'b0);

    load("li#xy"); mem[5] = 8'h0A;
    run_text(6, 1'b0);

    // Reset in the middle of the second pass
    load("add x1,x2,x3"); mem[12] = 8'h0A;
    begin_run(13, err);
    found = 1'b0;
    for (int k = 0; k < 3000 && !found; k++) begin
      tick();
      if (pass_out == 2'd2 && new_character && char_count == 6'd3) found = 1'b1;
    end
    chk("mid_pass2_reached", {63'd0, found}, 64'd1);
    rst_n_in = 1'b0;
    #1;
    chk("reset_mid_outputs",
        {21'd0, new_line, new_character, incoming_character, line_count, char_count,
         text_addr_out, pass_out, busy, done, error_flag}, 64'd0);
    repeat (3) tick();
    chk("reset_no_done", 64'(done_cnt), 64'd0);
    rst_n_in = 1'b1;
    exp_q.delete();
    tick();
    run_text(13, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
